fwd_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the ARM pipeline. It sits at the ID/EXE boundary.
- Internally tracks the last DEPTH issued instructions (dest, wb_en, is_load) in a shifting scoreboard.
- Produces per-source forward selects for the instruction in ID, a load-use / no-forward stall request, and a saturating stall-cycle counter.
- Replaces the fixed 2-stage combinational forwarder with depth, load latency and forwarding-off mode handled in one block.

---
 rtl/fwd_scoreboard_if.sv | 37 +++
 rtl/fwd_scoreboard.sv | 97 +++++++++
 tb/tb_fwd_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// ID-stage view of the forwarding/hazard unit: instruction fields in, forward selects and stall out.
// Latency: n/a (wires only). Backpressure: stall is driven back toward the master.
interface fwd_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             enable;
    logic             hold;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_used;
    logic             id_src2_used;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_is_load;
    logic [SEL_W-1:0] sel_src1;
    logic [SEL_W-1:0] sel_src2;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output enable, hold, flush, id_valid, id_src1, id_src2, id_src1_used,
               id_src2_used, id_dest, id_wb_en, id_is_load,
        input  sel_src1, sel_src2, stall, stall_cnt
    );

    modport slave (
        input  enable, hold, flush, id_valid, id_src1, id_src2, id_src1_used,
               id_src2_used, id_dest, id_wb_en, id_is_load,
        output sel_src1, sel_src2, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit at ID/EXE: tracks the last DEPTH writers, selects the youngest forward source.
// Latency: selects/stall are combinational; the scoreboard shifts one stage per unfrozen cycle.
// Backpressure: hold freezes all state; stall bubbles stage 1 and asks upstream to freeze PC/IF/ID.
module fwd_scoreboard #(
    parameter int REG_W    = 4,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    fwd_scoreboard_if.slave sb
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             is_load;
    } entry_t;

    entry_t           stage_q [1:DEPTH];
    entry_t           stage_d [1:DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    int   kmin1;
    int   kmin2;
    logic ld1;
    logic ld2;
    logic stall1;
    logic stall2;
    logic stall_w;

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        kmin1 = 0;
        kmin2 = 0;
        ld1   = 1'b0;
        ld2   = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb.id_valid && stage_q[k].vld && stage_q[k].wb_en) begin
                if (sb.id_src1_used && (stage_q[k].dest == sb.id_src1)) begin
                    kmin1 = k;
                    ld1   = stage_q[k].is_load;
                end
                if (sb.id_src2_used && (stage_q[k].dest == sb.id_src2)) begin
                    kmin2 = k;
                    ld2   = stage_q[k].is_load;
                end
            end
        end
    end

    // Forwarding off: any in-flight writer of a source blocks until it retires.
    always_comb begin
        stall1  = (kmin1 != 0) && (sb.enable ? (ld1 && (kmin1 <= LOAD_LAT)) : 1'b1);
        stall2  = (kmin2 != 0) && (sb.enable ? (ld2 && (kmin2 <= LOAD_LAT)) : 1'b1);
        stall_w = !sb.flush && (stall1 || stall2);
    end

    assign sb.sel_src1  = sb.enable ? SEL_W'(kmin1) : '0;
    assign sb.sel_src2  = sb.enable ? SEL_W'(kmin2) : '0;
    assign sb.stall     = stall_w;
    assign sb.stall_cnt = stall_cnt_q;

    always_comb begin
        stage_d     = stage_q;
        stall_cnt_d = stall_cnt_q;
        if (!sb.hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                stage_d[k] = stage_q[k-1];
            end
            if (sb.flush || stall_w || !sb.id_valid) begin
                stage_d[1] = '0;
            end else begin
                stage_d[1] = {1'b1, sb.id_dest, sb.id_wb_en, sb.id_is_load};
            end
            if (stall_w && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: queue-based reference model checked every cycle plus directed literal checks.
module tb_fwd_scoreboard;
    localparam int REG_W    = 4;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) sb ();

    fwd_scoreboard #(
        .REG_W   (REG_W),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (sb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit vld;
        int dest;
        bit wb;
        bit ld;
    } ent_t;

    // hist[0] is the most recently issued slot (stage 1).
    ent_t hist[$];
    int   cnt_m = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int youngest(int src, bit used);
        if (!used || !sb.id_valid) return 0;
        foreach (hist[i]) begin
            if (hist[i].vld && hist[i].wb && hist[i].dest == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit src_stalls(int k);
        if (k == 0) return 1'b0;
        if (!sb.enable) return 1'b1;
        return hist[k-1].ld && (k <= LOAD_LAT);
    endfunction

    function automatic bit exp_stall();
        if (sb.flush) return 1'b0;
        return src_stalls(youngest(int'(sb.id_src1), sb.id_src1_used)) ||
               src_stalls(youngest(int'(sb.id_src2), sb.id_src2_used));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            cnt_m = 0;
        end else if (!sb.hold) begin
            bit   s;
            ent_t e;
            s      = exp_stall();
            e.vld  = !(sb.flush || s || !sb.id_valid);
            e.dest = int'(sb.id_dest);
            e.wb   = sb.id_wb_en;
            e.ld   = sb.id_is_load;
            hist.push_front(e);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            if (s && cnt_m < CNT_MAX) cnt_m++;
        end
    end

    always @(negedge clk) begin
        chk("model_sel_src1", int'(sb.sel_src1),
            sb.enable ? youngest(int'(sb.id_src1), sb.id_src1_used) : 0);
        chk("model_sel_src2", int'(sb.sel_src2),
            sb.enable ? youngest(int'(sb.id_src2), sb.id_src2_used) : 0);
        chk("model_stall", int'(sb.stall), int'(exp_stall()));
        chk("model_stall_cnt", int'(sb.stall_cnt), cnt_m);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        sb.id_valid     = 1'b0;
        sb.id_src1      = '0;
        sb.id_src2      = '0;
        sb.id_src1_used = 1'b0;
        sb.id_src2_used = 1'b0;
        sb.id_dest      = '0;
        sb.id_wb_en     = 1'b0;
        sb.id_is_load   = 1'b0;
        sb.flush        = 1'b0;
        sb.hold         = 1'b0;
    endtask

    task automatic issue(int dest, bit wb, bit ld);
        idle();
        sb.id_valid   = 1'b1;
        sb.id_dest    = REG_W'(dest);
        sb.id_wb_en   = wb;
        sb.id_is_load = ld;
    endtask

    task automatic use_src(int s1, bit u1, int s2, bit u2);
        idle();
        sb.id_valid     = 1'b1;
        sb.id_src1      = REG_W'(s1);
        sb.id_src1_used = u1;
        sb.id_src2      = REG_W'(s2);
        sb.id_src2_used = u2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sb.enable = 1'b1;
        idle();
        #2;
        chk("reset_sel_src1", int'(sb.sel_src1), 0);
        chk("reset_sel_src2", int'(sb.sel_src2), 0);
        chk("reset_stall", int'(sb.stall), 0);
        chk("reset_stall_cnt", int'(sb.stall_cnt), 0);
        step();
        rst = 1'b0;
        step();

        // Reset mid-operation
        issue(3, 1, 0);
        step();
        use_src(3, 1, 0, 0);
        settle();
        chk("t1_fwd_before_rst", int'(sb.sel_src1), 1);
        rst = 1'b1;
        settle();
        chk("t1_sel_after_rst", int'(sb.sel_src1), 0);
        chk("t1_stall_after_rst", int'(sb.stall), 0);
        chk("t1_cnt_after_rst", int'(sb.stall_cnt), 0);
        rst = 1'b0;
        step();

        // ALU back-to-back
        issue(5, 1, 0);
        step();
        use_src(5, 1, 0, 0);
        settle();
        chk("t2_sel1_stage1", int'(sb.sel_src1), 1);
        step();
        use_src(0, 0, 5, 1);
        settle();
        chk("t2_sel2_stage2", int'(sb.sel_src2), 2);
        step();
        use_src(0, 0, 5, 1);
        settle();
        chk("t2_sel2_gone", int'(sb.sel_src2), 0);
        step();

        // Youngest wins
        issue(7, 1, 0);
        step();
        issue(7, 1, 0);
        step();
        use_src(7, 1, 0, 0);
        sb.id_dest  = REG_W'(7);
        sb.id_wb_en = 1'b0;
        settle();
        chk("t3_youngest", int'(sb.sel_src1), 1);
        step();
        use_src(7, 1, 0, 0);
        settle();
        chk("t3_skip_no_wb", int'(sb.sel_src1), 2);
        step();

        // Load-use
        do_reset();
        step();
        issue(2, 1, 1);
        step();
        use_src(0, 0, 2, 1);
        settle();
        chk("t4_stall", int'(sb.stall), 1);
        chk("t4_cnt0", int'(sb.stall_cnt), 0);
        step();
        settle();
        chk("t4_stall_released", int'(sb.stall), 0);
        chk("t4_sel2", int'(sb.sel_src2), 2);
        chk("t4_cnt1", int'(sb.stall_cnt), 1);
        step();
        idle();

        // Forwarding off
        do_reset();
        step();
        sb.enable = 1'b0;
        issue(4, 1, 0);
        step();
        use_src(4, 1, 0, 0);
        settle();
        chk("t5_stall_c1", int'(sb.stall), 1);
        chk("t5_sel_c1", int'(sb.sel_src1), 0);
        step();
        settle();
        chk("t5_stall_c2", int'(sb.stall), 1);
        chk("t5_sel_c2", int'(sb.sel_src1), 0);
        chk("t5_cnt_c2", int'(sb.stall_cnt), 1);
        step();
        settle();
        chk("t5_stall_c3", int'(sb.stall), 0);
        chk("t5_cnt_c3", int'(sb.stall_cnt), 2);
        step();
        idle();
        sb.enable = 1'b1;

        // hold / flush priority
        do_reset();
        step();
        issue(2, 1, 1);
        step();
        use_src(0, 0, 2, 1);
        sb.id_dest  = REG_W'(2);
        sb.id_wb_en = 1'b1;
        settle();
        chk("t6_stall", int'(sb.stall), 1);
        sb.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("t6_hold_stall", int'(sb.stall), 1);
            chk("t6_hold_cnt", int'(sb.stall_cnt), 0);
        end
        sb.hold  = 1'b0;
        sb.flush = 1'b1;
        settle();
        chk("t6_flush_stall", int'(sb.stall), 0);
        step();
        sb.flush = 1'b0;
        settle();
        chk("t6_bubble_sel2", int'(sb.sel_src2), 2);
        chk("t6_after_stall", int'(sb.stall), 0);
        chk("t6_after_cnt", int'(sb.stall_cnt), 0);
        step();

        // Saturation with forwarding off
        do_reset();
        step();
        sb.enable = 1'b0;
        issue(9, 1, 0);
        step();
        use_src(9, 1, 0, 0);
        step();
        step();
        settle();
        chk("sat_round1_cnt", int'(sb.stall_cnt), 2);
        chk("sat_round1_stall", int'(sb.stall), 0);
        step();
        issue(9, 1, 0);
        step();
        use_src(9, 1, 0, 0);
        step();
        settle();
        chk("sat_cnt3", int'(sb.stall_cnt), 3);
        chk("sat_still_stall", int'(sb.stall), 1);
        step();
        settle();
        chk("sat_hold_max", int'(sb.stall_cnt), 3);
        chk("sat_released", int'(sb.stall), 0);
        step();
        idle();
        sb.enable = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
